// File: rtl/ctrl_fsm_if.sv
// Bundle between the control sequencer and its environment: the program-ROM handshake in,
// and the state/IR/counter fields out to the control-signal decode unit.
interface ctrl_fsm_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned CW = 16
);
  logic [IW-1:0] rom_data;
  logic          rom_valid;
  logic          step;
  logic [3:0]    state;
  logic [3:0]    opcode;
  logic [3:0]    rd;
  logic [3:0]    rs;
  logic [3:0]    rt;
  logic          halted;
  logic [CW-1:0] instr_count;

  modport master (
    output rom_data, rom_valid, step,
    input  state, opcode, rd, rs, rt, halted, instr_count
  );

  modport slave (
    input  rom_data, rom_valid, step,
    output state, opcode, rd, rs, rt, halted, instr_count
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Main control sequencer: fetch, ROM wait, decode, ALU op, store; owns the instruction register.
// Optional single-step stall in S_STORE_RES and NOP decode is built when CTRL_STEP_EN is defined.
module ctrl_fsm #(
  parameter int unsigned IW = 16,
  parameter int unsigned CW = 16
) (
  input logic          clk_i,
  input logic          reset_i,
  ctrl_fsm_if.slave    bus
);

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StWaitRom  = 4'd2,
    StDecode   = 4'd3,
    StUlaOp    = 4'd4,
    StStoreRes = 4'd5,
    StHalt     = 4'd6
  } state_e;

  localparam logic [3:0] OpNop  = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e        state_q;
  logic [IW-1:0] ir_q;
  logic [CW-1:0] cnt_q;
  logic          halted_q;
  logic          step_ok;
  logic [3:0]    op;

`ifdef CTRL_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  assign op = ir_q[IW-1 -: 4];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StReset;
      ir_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      halted_q <= 1'b0;
      unique case (state_q)
        StReset: state_q <= StFetch;
        StFetch: state_q <= StWaitRom;
        StWaitRom: begin
          if (bus.rom_valid) begin
            ir_q    <= bus.rom_data;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (op == OpHalt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (op == OpNop) begin
            if (step_ok) begin
              state_q <= StFetch;
              cnt_q   <= cnt_q + CW'(1);
            end
          end else begin
            state_q <= StUlaOp;
          end
        end
        StUlaOp: state_q <= StStoreRes;
        StStoreRes: begin
          if (step_ok) begin
            state_q <= StFetch;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        StHalt: halted_q <= 1'b1;
        // Unused codes recover through reset state.
        default: state_q <= StReset;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.opcode      = ir_q[IW-1 -: 4];
  assign bus.rd          = ir_q[IW-5 -: 4];
  assign bus.rs          = ir_q[IW-9 -: 4];
  assign bus.rt          = ir_q[IW-13 -: 4];
  assign bus.halted      = halted_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomized bench for ctrl_fsm: an instruction-level plan drives the ROM port open-loop
// and a transaction model predicts state, IR fields, retired count and halted per cycle.
module tb_ctrl_fsm;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 8;
`ifdef CTRL_STEP_EN
  localparam bit StepBuild = 1'b1;
`else
  localparam bit StepBuild = 1'b0;
`endif

  logic clk;
  logic reset;
  ctrl_fsm_if #(.IW(IW), .CW(CW)) bus ();

  ctrl_fsm #(.IW(IW), .CW(CW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0]    e_state;
  logic [15:0]   e_ir;
  logic [CW-1:0] e_cnt;
  logic          e_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rw();
    return 16'($urandom);
  endfunction

  // Step value for cycles that release a stall; ignored in the default build.
  function automatic bit go_step();
    return StepBuild ? 1'b1 : rb();
  endfunction

  task automatic tick(input bit rst, input bit rv, input logic [15:0] data, input bit stp);
    @(negedge clk);
    reset         = rst;
    bus.rom_valid = rv;
    bus.rom_data  = data;
    bus.step      = stp;
    @(posedge clk);
    #1;
    check("state", 32'(bus.state), 32'(e_state));
    check("opcode", 32'(bus.opcode), 32'(e_ir[15:12]));
    check("rd", 32'(bus.rd), 32'(e_ir[11:8]));
    check("rs", 32'(bus.rs), 32'(e_ir[7:4]));
    check("rt", 32'(bus.rt), 32'(e_ir[3:0]));
    check("instr_count", 32'(bus.instr_count), 32'(e_cnt));
    check("halted", 32'(bus.halted), 32'(e_halted));
  endtask

  // Reset edge, then the one idle cycle that lands in S_FETCH.
  task automatic do_reset();
    e_state = 4'd0; e_ir = '0; e_cnt = '0; e_halted = 1'b0;
    tick(1'b1, rb(), rw(), rb());
    e_state = 4'd1;
    tick(1'b0, rb(), rw(), rb());
  endtask

  task automatic stall(input int n);
`ifdef CTRL_STEP_EN
    for (int i = 0; i < n; i++) tick(1'b0, rb(), rw(), 1'b0);
`endif
  endtask

  // Runs one instruction starting from S_FETCH; ends in S_FETCH (or S_HALT for HALT).
  task automatic run_instr(input logic [15:0] w, input int waits, input int stalls);
    e_state = 4'd2;
    tick(1'b0, rb(), rw(), rb());
    for (int i = 0; i < waits; i++) tick(1'b0, 1'b0, rw(), rb());
    e_ir = w;
    e_state = 4'd3;
    tick(1'b0, 1'b1, w, rb());
    if (w[15:12] == 4'hF) begin
      e_state = 4'd6; e_halted = 1'b1;
      tick(1'b0, rb(), rw(), rb());
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, rw(), rb());
    end else if (w[15:12] == 4'hE) begin
      stall(stalls);
      e_cnt = e_cnt + CW'(1);
      e_state = 4'd1;
      tick(1'b0, rb(), rw(), go_step());
    end else begin
      e_state = 4'd4;
      tick(1'b0, rb(), rw(), rb());
      e_state = 4'd5;
      // ROM glitch during the ALU cycle must not touch IR.
      tick(1'b0, 1'b1, ~w, rb());
      stall(stalls);
      e_cnt = e_cnt + CW'(1);
      e_state = 4'd1;
      tick(1'b0, rb(), rw(), go_step());
    end
  endtask

  // Reset mid-instruction, either in S_WAIT_ROM or in S_ULA_OP.
  task automatic abort_run(input bit at_ula);
    logic [15:0] w;
    e_state = 4'd2;
    tick(1'b0, rb(), rw(), rb());
    if (at_ula) begin
      w = rw();
      w[15:12] = 4'($urandom_range(0, 13));
      e_ir = w; e_state = 4'd3;
      tick(1'b0, 1'b1, w, rb());
      e_state = 4'd4;
      tick(1'b0, rb(), rw(), rb());
    end else begin
      tick(1'b0, 1'b0, rw(), rb());
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    bus.rom_valid = 1'b0;
    bus.rom_data  = '0;
    bus.step      = 1'b0;
    do_reset();

    run_instr(16'h1234, 0, 0);
    run_instr(16'h5678, 3, 5);
    run_instr(16'hE000, 1, 2);
    run_instr(16'hF000, 0, 0);
    do_reset();

    abort_run(1'b0);
    abort_run(1'b1);

    // Counter wrap: 2^CW + 4 NOPs from zero.
    for (int i = 0; i < (1 << CW) + 4; i++) run_instr(16'hE000 | 16'(i), 0, 0);
    do_reset();

    for (int n = 0; n < 200; n++) begin
      int r;
      logic [15:0] w;
      r = $urandom_range(0, 39);
      w = rw();
      if (r == 0) begin
        w[15:12] = 4'hF;
        run_instr(w, $urandom_range(0, 3), 0);
        do_reset();
      end else if (r == 1 || r == 2) begin
        abort_run(r == 2);
      end else begin
        if (r < 11) w[15:12] = 4'hE;
        else        w[15:12] = 4'($urandom_range(0, 13));
        run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
